crossbar_sched: RTL and testbench

CROSSBAR_SCHED -- requirements
Module: crossbar_sched

---
 rtl/crossbar_sched_pkg.sv | 24 ++
 rtl/crossbar_sched_rr_arbiter.sv | 30 +++
 rtl/crossbar_sched.sv | 120 ++++++++++++
 tb/tb_crossbar_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_sched_pkg.sv
// Shared types and control-word layout helpers for the crossbar scheduler.
package crossbar_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam int CTL_IN_LSB = 0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ctl_out_lsb(input int in_w);
        return in_w;
    endfunction

    function automatic int ctl_en_bit(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/crossbar_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/crossbar_sched.sv
// Crossbar connection scheduler: grant one input, program the crossbar,
// then hold the path for a burst of len+1 messages.
module crossbar_sched
    import crossbar_sched_pkg::*;
#(
    parameter  int N_INPUTS          = 2,
    parameter  int N_OUTPUTS         = 2,
    parameter  int CONTROL_BIT_WIDTH = 42,
    parameter  int LEN_W             = 8,
    localparam int IN_W              = idx_w(N_INPUTS),
    localparam int OUT_W             = idx_w(N_OUTPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_INPUTS-1:0]          req_val,
    input  logic [N_INPUTS*OUT_W-1:0]    req_dest,
    input  logic [N_INPUTS*LEN_W-1:0]    req_len,
    output logic [N_INPUTS-1:0]          req_rdy,
    output logic [CONTROL_BIT_WIDTH-1:0] control,
    output logic                         control_val,
    input  logic                         control_rdy,
    input  logic                         xfer_fire,
    output logic                         busy,
    output logic                         err
);

    localparam int OUT_LSB = ctl_out_lsb(IN_W);
    localparam int EN_BIT  = ctl_en_bit(IN_W, OUT_W);

    state_e              state_q, state_d;
    logic [IN_W-1:0]     ptr_q, ptr_d;
    logic [IN_W-1:0]     in_q, in_d;
    logic [OUT_W-1:0]    dest_q, dest_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [N_INPUTS-1:0] arb_gnt, grant;
    logic [IN_W-1:0]     arb_idx;
    logic                arb_any;
    logic [OUT_W-1:0]    sel_dest;
    logic [LEN_W-1:0]    sel_len;

    rr_arbiter #(.N(N_INPUTS), .IW(IN_W)) u_arb (
        .req (req_val),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_dest = req_dest[int'(arb_idx)*OUT_W +: OUT_W];
    assign sel_len  = req_len[int'(arb_idx)*LEN_W +: LEN_W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        in_d    = in_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        grant   = '0;
        case (state_q)
            IDLE: begin
                if (arb_any && !reset) begin
                    grant  = arb_gnt;
                    in_d   = arb_idx;
                    dest_d = sel_dest;
                    cnt_d  = sel_len;
                    ptr_d  = (int'(arb_idx) == N_INPUTS-1) ? '0 : arb_idx + 1'b1;
                    // Out-of-range destinations are dropped after the grant.
                    if (int'(sel_dest) < N_OUTPUTS) state_d = CFG;
                    else                            err_d   = 1'b1;
                end
            end
            CFG: begin
                if (control_rdy) state_d = XFER;
            end
            XFER: begin
                if (xfer_fire) begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            in_q    <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            in_q    <= in_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        control = '0;
        if (state_q == CFG) begin
            control[CTL_IN_LSB +: IN_W] = in_q;
            control[OUT_LSB +: OUT_W]   = dest_q;
            control[EN_BIT]             = 1'b1;
        end
    end

    assign req_rdy     = grant;
    assign control_val = (state_q == CFG);
    assign busy        = (state_q != IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_crossbar_sched.sv
// Scoreboard bench: DUT a uses default sizing, DUT b has 3 outputs for
// illegal-destination coverage.
module tb_crossbar_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT a: N_INPUTS=2, N_OUTPUTS=2 (OUT_W=1)
    logic        a_reset, a_ctl_rdy, a_xfer, a_ctl_val, a_busy, a_err;
    logic [1:0]  a_req_val, a_req_dest, a_req_rdy;
    logic [15:0] a_req_len;
    logic [41:0] a_ctl;

    // DUT b: N_INPUTS=2, N_OUTPUTS=3 (OUT_W=2)
    logic        b_reset, b_ctl_rdy, b_xfer, b_ctl_val, b_busy, b_err;
    logic [1:0]  b_req_val, b_req_rdy;
    logic [3:0]  b_req_dest;
    logic [15:0] b_req_len;
    logic [41:0] b_ctl;

    crossbar_sched dut_a (
        .clk(clk), .reset(a_reset), .req_val(a_req_val), .req_dest(a_req_dest),
        .req_len(a_req_len), .req_rdy(a_req_rdy), .control(a_ctl),
        .control_val(a_ctl_val), .control_rdy(a_ctl_rdy), .xfer_fire(a_xfer),
        .busy(a_busy), .err(a_err)
    );

    crossbar_sched #(.N_OUTPUTS(3)) dut_b (
        .clk(clk), .reset(b_reset), .req_val(b_req_val), .req_dest(b_req_dest),
        .req_len(b_req_len), .req_rdy(b_req_rdy), .control(b_ctl),
        .control_val(b_ctl_val), .control_rdy(b_ctl_rdy), .xfer_fire(b_xfer),
        .busy(b_busy), .err(b_err)
    );

    logic [1:0]  a_gq[$], b_gq[$];
    logic [41:0] a_cq[$], b_cq[$];
    bit          b_eq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected event value 0x%0h expected none", nm, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant, accepted control word and err pulse must match
    // the next queued expectation.
    always @(negedge clk) begin
        if (a_req_rdy != 2'b00) begin
            if (a_gq.size() == 0) unexp("a_grant", a_req_rdy);
            else chk("a_grant", a_req_rdy, a_gq.pop_front());
        end
        if (a_ctl_val && a_ctl_rdy) begin
            if (a_cq.size() == 0) unexp("a_control", a_ctl);
            else chk("a_control", a_ctl, a_cq.pop_front());
        end
        if (a_err === 1'b1) unexp("a_err", a_err);
        if (b_req_rdy != 2'b00) begin
            if (b_gq.size() == 0) unexp("b_grant", b_req_rdy);
            else chk("b_grant", b_req_rdy, b_gq.pop_front());
        end
        if (b_ctl_val && b_ctl_rdy) begin
            if (b_cq.size() == 0) unexp("b_control", b_ctl);
            else chk("b_control", b_ctl, b_cq.pop_front());
        end
        if (b_err === 1'b1) begin
            if (b_eq.size() == 0) unexp("b_err", b_err);
            else chk("b_err", b_err, 64'(b_eq.pop_front()));
        end
    end

    task automatic chk_a_zero(input string nm);
        chk({nm, "_req_rdy"}, a_req_rdy, 0);
        chk({nm, "_control"}, a_ctl, 0);
        chk({nm, "_control_val"}, a_ctl_val, 0);
        chk({nm, "_busy"}, a_busy, 0);
        chk({nm, "_err"}, a_err, 0);
    endtask

    initial begin
        a_reset = 1; a_req_val = 0; a_req_dest = 0; a_req_len = 0; a_ctl_rdy = 0; a_xfer = 0;
        b_reset = 1; b_req_val = 0; b_req_dest = 0; b_req_len = 0; b_ctl_rdy = 0; b_xfer = 0;
        repeat (2) step();
        a_reset = 0; b_reset = 0;
        @(negedge clk);
        chk_a_zero("rst");
        chk("rst_b_busy", b_busy, 0);

        // Single request: input 0 -> output 1, len 2 (three messages)
        step();
        a_req_val = 2'b01; a_req_dest = 2'b01; a_req_len = 16'h0002; a_ctl_rdy = 1;
        a_gq.push_back(2'b01); a_cq.push_back(42'h006);
        @(negedge clk); chk("single_busy_grant", a_busy, 0);
        step(); a_req_val = 0;
        @(negedge clk); chk("single_cfg_val", a_ctl_val, 1); chk("single_cfg_busy", a_busy, 1);
        step();
        @(negedge clk); chk("single_xfer_val", a_ctl_val, 0); chk("single_xfer_ctl", a_ctl, 0);
        step(); a_xfer = 1;
        step();
        @(negedge clk); chk("single_busy_after1", a_busy, 1);
        step();
        @(negedge clk); chk("single_busy_after2", a_busy, 1);
        step(); a_xfer = 0;
        @(negedge clk); chk("single_idle_after3", a_busy, 0);

        // Contention: both inputs requesting, len 0, alternate from ptr 0
        step(); a_reset = 1;
        step(); a_reset = 0;
        step();
        a_req_val = 2'b11; a_req_dest = 2'b00; a_req_len = 0; a_xfer = 1; a_ctl_rdy = 1;
        a_gq.push_back(2'b01); a_gq.push_back(2'b10); a_gq.push_back(2'b01);
        a_cq.push_back(42'h004); a_cq.push_back(42'h005); a_cq.push_back(42'h004);
        repeat (7) step();
        a_req_val = 0;
        repeat (2) step();
        a_xfer = 0;
        @(negedge clk); chk("cont_idle", a_busy, 0);

        // Backpressure: input 1 -> output 1, control_rdy low for 5 cycles
        step();
        a_req_val = 2'b10; a_req_dest = 2'b10; a_req_len = 0; a_ctl_rdy = 0;
        a_gq.push_back(2'b10); a_cq.push_back(42'h007);
        step(); a_req_val = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_val_held", a_ctl_val, 1);
            chk("bp_ctl_stable", a_ctl, 42'h007);
            step();
        end
        a_ctl_rdy = 1;
        step(); a_ctl_rdy = 0;
        @(negedge clk); chk("bp_xfer_val", a_ctl_val, 0); chk("bp_xfer_busy", a_busy, 1);
        step(); a_xfer = 1;
        step(); a_xfer = 0;
        @(negedge clk); chk("bp_done", a_busy, 0);

        // xfer_fire in IDLE and CFG must not disturb state or count
        step(); a_xfer = 1;
        @(negedge clk); chk("fire_idle_busy", a_busy, 0);
        step(); a_xfer = 0;
        a_req_val = 2'b01; a_req_dest = 2'b00; a_req_len = 16'h0001; a_ctl_rdy = 0;
        a_gq.push_back(2'b01); a_cq.push_back(42'h004);
        step(); a_req_val = 0; a_xfer = 1;
        repeat (2) step();
        @(negedge clk); chk("fire_cfg_val", a_ctl_val, 1);
        step(); a_xfer = 0; a_ctl_rdy = 1;
        step(); a_ctl_rdy = 0; a_xfer = 1;
        step();
        @(negedge clk); chk("fire_cnt_kept", a_busy, 1);
        step(); a_xfer = 0;
        @(negedge clk); chk("fire_done", a_busy, 0);

        // Reset mid-XFER after 1 of 4 messages
        step();
        a_req_val = 2'b10; a_req_dest = 2'b10; a_req_len = 16'h0300; a_ctl_rdy = 1;
        a_gq.push_back(2'b10); a_cq.push_back(42'h007);
        step(); a_req_val = 0;
        step(); a_xfer = 1;
        step(); a_xfer = 0; a_reset = 1; a_req_val = 2'b11;
        @(negedge clk); chk("rst_no_grant", a_req_rdy, 0);
        step(); a_reset = 0; a_req_val = 0; a_xfer = 1;
        @(negedge clk); chk_a_zero("mid_rst");
        step(); a_xfer = 0; a_req_val = 2'b11; a_req_dest = 0; a_req_len = 0;
        a_gq.push_back(2'b01); a_cq.push_back(42'h004);
        @(negedge clk); chk("mid_rst_fire_ignored", a_busy, 0);
        step(); a_req_val = 0;
        step(); a_xfer = 1;
        step(); a_xfer = 0;
        @(negedge clk); chk("mid_rst_done", a_busy, 0);

        // Illegal destination on the 3-output instance, then a legal one
        step();
        b_req_val = 2'b01; b_req_dest = 4'b0011; b_req_len = 0; b_ctl_rdy = 1;
        b_gq.push_back(2'b01); b_eq.push_back(1'b1);
        @(negedge clk); chk("ill_err_grant_cycle", b_err, 0);
        step(); b_req_val = 0;
        @(negedge clk); chk("ill_val", b_ctl_val, 0); chk("ill_busy", b_busy, 0);
        step();
        @(negedge clk); chk("ill_err_cleared", b_err, 0); chk("ill_val2", b_ctl_val, 0);
        b_req_val = 2'b10; b_req_dest = 4'b1000;
        b_gq.push_back(2'b10); b_cq.push_back(42'h00D);
        step(); b_req_val = 0;
        @(negedge clk); chk("legal_cfg_val", b_ctl_val, 1);
        step(); b_xfer = 1;
        step(); b_xfer = 0;
        @(negedge clk); chk("legal_done", b_busy, 0);

        repeat (2) step();
        chk("a_grants_left", a_gq.size(), 0);
        chk("a_ctl_left", a_cq.size(), 0);
        chk("b_grants_left", b_gq.size(), 0);
        chk("b_ctl_left", b_cq.size(), 0);
        chk("b_err_left", b_eq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
